// File: rtl/mem_responder_if.sv
// Request/response bundle between the CPU memory controller (master) and mem_responder (slave).
`timescale 1ns/1ps
interface mem_responder_if;
    logic        req_valid;
    logic        req_write;
    logic        req_ifetch;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;
    logic        req_ready;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_write, req_ifetch, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_write, req_ifetch, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/mem_responder.sv
// Single-outstanding word memory responder with programmable wait states.
// Optional build macro MEM_WPROT_EN write-protects words below PROT_LIMIT for data writes.
`timescale 1ns/1ps
module mem_responder #(
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 1,
    parameter int PROT_LIMIT  = 64
) (
    input  logic            CLK,
    input  logic            Reset,
    mem_responder_if.slave  bus
);
    localparam int         AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);
    localparam logic [16:0] DEPTH_L  = 17'(DEPTH);
    localparam logic [16:0] PROT_L   = 17'(PROT_LIMIT);
`ifdef MEM_WPROT_EN
    localparam bit WPROT_EN = 1'b1;
`else
    localparam bit WPROT_EN = 1'b0;
`endif

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_WAIT   = 2'd1;
    localparam logic [1:0] S_ACCESS = 2'd2;
    localparam logic [1:0] S_RESP   = 2'd3;

    logic [15:0] mem [DEPTH];

    logic [1:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        wr_q, wr_d;
    logic        ife_q, ife_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic        ready_q, ready_d;
    logic        valid_q, valid_d;
    logic [15:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic        oob, prot_hit, bad_req, mem_we;
    logic [15:0] mem_rd;

    // Ifetch writes are rejected the same way as out-of-range addresses.
    assign oob      = ({1'b0, addr_q} >= DEPTH_L) || (wr_q && ife_q);
    assign prot_hit = WPROT_EN && wr_q && !ife_q && ({1'b0, addr_q} < PROT_L);
    assign bad_req  = oob || prot_hit;
    assign mem_rd   = mem[addr_q[AW-1:0]];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        ife_d   = ife_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        ready_d = ready_q;
        valid_d = 1'b0;
        rdata_d = rdata_q;
        err_d   = err_q;
        mem_we  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.req_valid) begin
                    wr_d    = bus.req_write;
                    ife_d   = bus.req_ifetch;
                    addr_d  = bus.req_addr;
                    wdata_d = bus.req_wdata;
                    ready_d = 1'b0;
                    if (WAIT_CYCLES == 0) begin
                        state_d = S_ACCESS;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = WAIT_INIT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) state_d = S_ACCESS;
                else               cnt_d   = cnt_q - 4'd1;
            end
            S_ACCESS: begin
                // Response is registered here so rsp_valid is high during RESP.
                err_d   = bad_req;
                rdata_d = (bad_req || wr_q) ? 16'h0000 : mem_rd;
                mem_we  = wr_q && !bad_req;
                valid_d = 1'b1;
                state_d = S_RESP;
            end
            default: begin
                ready_d = 1'b1;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            wr_q    <= 1'b0;
            ife_q   <= 1'b0;
            addr_q  <= 16'h0000;
            wdata_q <= 16'h0000;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
            rdata_q <= 16'h0000;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            ife_q   <= ife_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            ready_q <= ready_d;
            valid_q <= valid_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Array is never cleared; mem_we is already dead once Reset forces IDLE.
    always_ff @(posedge CLK) begin
        if (mem_we) mem[addr_q[AW-1:0]] <= wdata_q;
    end

    assign bus.req_ready = ready_q;
    assign bus.rsp_valid = valid_q;
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;
endmodule
